// File: rtl/sysinfo_fetch.sv
// Wishbone master that reads the five system-info registers (clock frequency, UART base/IRQ,
// DRAM base/size) from a responder at BASE_ADR and latches them, with retry and timeout handling.
module sysinfo_fetch #(
    parameter logic [31:0] BASE_ADR  = 32'h0,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic [31:0] dat_i,
    output logic [31:0] freq,
    output logic [31:0] uart_base,
    output logic [31:0] uart_irq,
    output logic [31:0] dram_base,
    output logic [31:0] dram_size,
    output logic        busy,
    output logic        valid,
    output logic        error,
    output logic [2:0]  err_index
);

    typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, FAIL} state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

    state_t      state;
    logic [2:0]  index;
    logic [7:0]  retry_cnt;
    logic [15:0] tmo_cnt;
    logic        advance;

    assign dat_o = 32'h0;
    assign we_o  = 1'b0;
    assign sel_o = 4'hf;

    function automatic logic [31:0] reg_adr(input logic [2:0] idx);
        return BASE_ADR + {27'd0, idx, 2'b00};
    endfunction

    // advance remembers whether the GAP that follows should move to the next register
    // (after an ack) or reissue the same one (after a retry).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            index     <= 3'd0;
            retry_cnt <= 8'd0;
            tmo_cnt   <= 16'd0;
            advance   <= 1'b0;
            adr_o     <= 32'h0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            freq      <= 32'h0;
            uart_base <= 32'h0;
            uart_irq  <= 32'h0;
            dram_base <= 32'h0;
            dram_size <= 32'h0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            error     <= 1'b0;
            err_index <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state     <= REQ;
                        index     <= 3'd0;
                        retry_cnt <= 8'd0;
                        tmo_cnt   <= 16'd0;
                        valid     <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        adr_o     <= reg_adr(3'd0);
                    end
                end
                REQ: begin
                    if (err_i || (rty_i && retry_cnt >= RETRY_LIM) ||
                        (!rty_i && !ack_i && tmo_cnt == TMO_LAST)) begin
                        state     <= FAIL;
                        error     <= 1'b1;
                        err_index <= index;
                        busy      <= 1'b0;
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                    end else if (rty_i) begin
                        state     <= GAP;
                        retry_cnt <= retry_cnt + 8'd1;
                        advance   <= 1'b0;
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                    end else if (ack_i) begin
                        case (index)
                            3'd0:    freq      <= dat_i;
                            3'd1:    uart_base <= dat_i;
                            3'd2:    uart_irq  <= dat_i;
                            3'd3:    dram_base <= dat_i;
                            3'd4:    dram_size <= dat_i;
                            default: ;
                        endcase
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        if (index == 3'd4) begin
                            state <= DONE;
                            valid <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= GAP;
                            retry_cnt <= 8'd0;
                            advance   <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                GAP: begin
                    state   <= REQ;
                    tmo_cnt <= 16'd0;
                    cyc_o   <= 1'b1;
                    stb_o   <= 1'b1;
                    if (advance) begin
                        index <= 3'(index + 3'd1);
                        adr_o <= reg_adr(3'(index + 3'd1));
                    end else begin
                        adr_o <= reg_adr(index);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysinfo_fetch.sv
// Bench for sysinfo_fetch: a configurable Wishbone responder plus an address scoreboard
// that checks every request the master issues against the expected address sequence.
module tb_sysinfo_fetch;

    localparam logic [31:0] BASE = 32'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        cyc_o, stb_o, we_o, ack_i, err_i, rty_i;
    logic [3:0]  sel_o;
    logic [31:0] freq, uart_base, uart_irq, dram_base, dram_size;
    logic        busy, valid, error;
    logic [2:0]  err_index;

    always #5 clk = ~clk;

    sysinfo_fetch #(.BASE_ADR(BASE), .TIMEOUT(16), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .adr_o(adr_o), .dat_o(dat_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .dat_i(dat_i),
        .freq(freq), .uart_base(uart_base), .uart_irq(uart_irq),
        .dram_base(dram_base), .dram_size(dram_size),
        .busy(busy), .valid(valid), .error(error), .err_index(err_index)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_adr_q[$];
    logic [31:0] resp_data[5];
    logic [31:0] mon_exp;
    int err_at = -1, ackerr_at = -1, silent_at = -1, rty_at = -1;
    int rty_limit = 0, rty_base = 0, rty_seen = 0;
    logic [2:0] resp_idx;
    logic req_on;
    logic prev_req = 1'b0;

    // Responder: answers on the same cycle the request is presented, behaviour chosen per index.
    assign req_on   = cyc_o && stb_o;
    assign resp_idx = 3'((adr_o - BASE) >> 2);
    assign rty_i = req_on && int'(resp_idx) == rty_at && (rty_seen - rty_base) < rty_limit;
    assign err_i = req_on && (int'(resp_idx) == err_at || int'(resp_idx) == ackerr_at);
    assign ack_i = req_on && !rty_i && int'(resp_idx) != err_at && int'(resp_idx) != silent_at;
    assign dat_i = (req_on && resp_idx < 3'd5) ? resp_data[resp_idx] : 32'hDEAD_BEEF;

    always @(posedge clk) if (rty_i) rty_seen <= rty_seen + 1;

    // Scoreboard: each new request (rising cyc/stb) must match the next expected address.
    always @(negedge clk) begin
        if (req_on && !prev_req) begin
            n_checks++;
            if (exp_adr_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL adr_seq: unexpected request adr_o=%h, none expected", adr_o);
            end else begin
                mon_exp = exp_adr_q.pop_front();
                if (adr_o !== mon_exp) begin
                    n_fail++;
                    $display("[TB] FAIL adr_seq: adr_o=%h expected %h", adr_o, mon_exp);
                end
            end
        end
        prev_req = req_on;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_data(input logic [31:0] a, b, c, d, e);
        resp_data[0] = a; resp_data[1] = b; resp_data[2] = c; resp_data[3] = d; resp_data[4] = e;
    endtask

    task automatic config_resp(input int e_at, input int ae_at, input int s_at, input int r_at, input int r_lim);
        err_at = e_at; ackerr_at = ae_at; silent_at = s_at; rty_at = r_at;
        rty_limit = r_lim; rty_base = rty_seen;
    endtask

    task automatic push_adrs(input int n);
        for (int i = 0; i < n; i++) exp_adr_q.push_back(BASE + 32'(4 * i));
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = 0;
        while (!(valid || error) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        config_resp(-1, -1, -1, -1, 0);
        repeat (2) @(negedge clk);
        n_checks++; if (adr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_adr: got %h want 0", adr_o); end
        n_checks++; if ({cyc_o, stb_o, busy, valid, error} !== 5'b0) begin n_fail++; $display("[TB] FAIL rst_flags: got %b want 00000", {cyc_o, stb_o, busy, valid, error}); end
        n_checks++; if (err_index !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_err_index: got %0d want 0", err_index); end
        n_checks++; if ({freq, uart_base, uart_irq, dram_base, dram_size} !== 160'h0) begin n_fail++; $display("[TB] FAIL rst_values: nonzero value register after reset"); end
        n_checks++; if ({we_o, sel_o, dat_o} !== {1'b0, 4'hf, 32'h0}) begin n_fail++; $display("[TB] FAIL const_outputs: we=%b sel=%h dat=%h want 0 f 0", we_o, sel_o, dat_o); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({cyc_o, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_after_rst: cyc=%b busy=%b want 0 0", cyc_o, busy); end
    endtask

    task automatic test_full_fetch;
        int cycles;
        set_data(32'd100, 32'h9000_0000, 32'd2, 32'd0, 32'h0800_0000);
        config_resp(-1, -1, -1, -1, 0);
        push_adrs(5);
        pulse_start();
        wait_end(40, cycles);
        n_checks++; if (cycles !== 9) begin n_fail++; $display("[TB] FAIL full_latency: got %0d cycles want 9", cycles); end
        n_checks++; if ({valid, error, busy, cyc_o} !== 4'b1000) begin n_fail++; $display("[TB] FAIL full_flags: valid/error/busy/cyc=%b want 1000", {valid, error, busy, cyc_o}); end
        n_checks++; if (freq !== 32'd100 || uart_base !== 32'h9000_0000) begin n_fail++; $display("[TB] FAIL full_vals01: got %h %h want 64 90000000", freq, uart_base); end
        n_checks++; if (uart_irq !== 32'd2 || dram_base !== 32'd0 || dram_size !== 32'h0800_0000) begin n_fail++; $display("[TB] FAIL full_vals234: got %h %h %h want 2 0 08000000", uart_irq, dram_base, dram_size); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL full_adr_count: %0d expected requests missing", exp_adr_q.size()); end
    endtask

    task automatic test_err_abort;
        int cycles;
        set_data(32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5);
        config_resp(2, -1, -1, -1, 0);
        push_adrs(3);
        pulse_start();
        wait_end(40, cycles);
        n_checks++; if (cycles !== 5) begin n_fail++; $display("[TB] FAIL err_latency: got %0d cycles want 5", cycles); end
        n_checks++; if ({error, valid, busy, cyc_o, err_index} !== {4'b1000, 3'd2}) begin n_fail++; $display("[TB] FAIL err_flags: e/v/b/c=%b idx=%0d want 1000 2", {error, valid, busy, cyc_o}, err_index); end
        n_checks++; if (freq !== 32'hA1 || uart_base !== 32'hA2) begin n_fail++; $display("[TB] FAIL err_latched: got %h %h want a1 a2", freq, uart_base); end
        n_checks++; if (uart_irq !== 32'd2 || dram_base !== 32'd0 || dram_size !== 32'h0800_0000) begin n_fail++; $display("[TB] FAIL err_kept: got %h %h %h want 2 0 08000000", uart_irq, dram_base, dram_size); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL err_adr_count: %0d expected requests missing", exp_adr_q.size()); end
    endtask

    task automatic test_retry;
        int cycles;
        set_data(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5);
        config_resp(-1, -1, -1, 1, 4);
        exp_adr_q.push_back(BASE);
        repeat (4) exp_adr_q.push_back(BASE + 32'h4);
        pulse_start();
        wait_end(40, cycles);
        n_checks++; if (cycles !== 9) begin n_fail++; $display("[TB] FAIL retry_latency: got %0d cycles want 9", cycles); end
        n_checks++; if ({error, valid, err_index} !== {2'b10, 3'd1}) begin n_fail++; $display("[TB] FAIL retry_flags: e/v=%b idx=%0d want 10 1", {error, valid}, err_index); end
        n_checks++; if (freq !== 32'hB1 || uart_base !== 32'hA2) begin n_fail++; $display("[TB] FAIL retry_vals: got %h %h want b1 a2", freq, uart_base); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL retry_adr_count: %0d expected requests missing", exp_adr_q.size()); end
    endtask

    task automatic test_timeout;
        int cycles, hi;
        set_data(32'hC0, 32'hC0, 32'hC0, 32'hC0, 32'hC0);
        config_resp(-1, -1, 0, -1, 0);
        push_adrs(1);
        pulse_start();
        cycles = 0;
        hi = cyc_o ? 1 : 0;
        while (!error && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (cyc_o) hi++;
        end
        n_checks++; if (hi !== 16) begin n_fail++; $display("[TB] FAIL timeout_len: cyc_o high %0d cycles want 16", hi); end
        n_checks++; if ({error, err_index, cyc_o} !== {1'b1, 3'd0, 1'b0}) begin n_fail++; $display("[TB] FAIL timeout_flags: error=%b idx=%0d cyc=%b want 1 0 0", error, err_index, cyc_o); end
        n_checks++; if (freq !== 32'hB1) begin n_fail++; $display("[TB] FAIL timeout_kept: freq=%h want b1", freq); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL timeout_adr_count: %0d expected requests missing", exp_adr_q.size()); end
    endtask

    task automatic test_ack_err;
        int cycles;
        set_data(32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5);
        config_resp(-1, 3, -1, -1, 0);
        push_adrs(4);
        pulse_start();
        wait_end(40, cycles);
        n_checks++; if ({error, valid, err_index} !== {2'b10, 3'd3}) begin n_fail++; $display("[TB] FAIL ackerr_flags: e/v=%b idx=%0d want 10 3", {error, valid}, err_index); end
        n_checks++; if (uart_irq !== 32'hC3 || dram_base !== 32'd0 || dram_size !== 32'h0800_0000) begin n_fail++; $display("[TB] FAIL ackerr_vals: got %h %h %h want c3 0 08000000", uart_irq, dram_base, dram_size); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL ackerr_adr_count: %0d expected requests missing", exp_adr_q.size()); end
    endtask

    task automatic test_reset_mid;
        int cycles;
        bit found;
        set_data(32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5);
        config_resp(-1, -1, 3, -1, 0);
        push_adrs(4);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_on && adr_o == BASE + 32'hC) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL rstmid_reach: index 3 request seen=%b want 1", found); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({cyc_o, stb_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL rstmid_async: cyc/stb=%b want 00 before clock edge", {cyc_o, stb_o}); end
        n_checks++; if ({freq, uart_base, uart_irq, dram_base, dram_size, adr_o} !== 192'h0 || {busy, valid, error, err_index} !== 6'h0) begin n_fail++; $display("[TB] FAIL rstmid_zero: freq=%h adr=%h flags=%b want all 0", freq, adr_o, {busy, valid, error, err_index}); end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL rstmid_adr_count: %0d expected requests missing", exp_adr_q.size()); end
        set_data(32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5);
        config_resp(-1, -1, -1, -1, 0);
        push_adrs(5);
        pulse_start();
        wait_end(40, cycles);
        n_checks++; if (cycles !== 9 || {valid, error} !== 2'b10) begin n_fail++; $display("[TB] FAIL rstmid_refetch: cycles=%0d v/e=%b want 9 10", cycles, {valid, error}); end
        n_checks++; if (freq !== 32'hE1 || dram_size !== 32'hE5 || dram_base !== 32'hE4) begin n_fail++; $display("[TB] FAIL rstmid_vals: got %h %h %h want e1 e4 e5", freq, dram_base, dram_size); end
    endtask

    task automatic test_back_to_back;
        int cycles;
        set_data(32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5);
        push_adrs(5);
        pulse_start();
        cycles = 0;
        while (!valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
            start = (cycles == 3);
        end
        start = 1'b0;
        n_checks++; if (cycles !== 9) begin n_fail++; $display("[TB] FAIL b2b_ignore: got %0d cycles want 9", cycles); end
        n_checks++; if (uart_base !== 32'hF2 || uart_irq !== 32'hF3) begin n_fail++; $display("[TB] FAIL b2b_vals: got %h %h want f2 f3", uart_base, uart_irq); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL b2b_adr_count: %0d expected requests missing", exp_adr_q.size()); end
        set_data(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
        push_adrs(5);
        pulse_start();
        n_checks++; if ({valid, busy} !== 2'b01) begin n_fail++; $display("[TB] FAIL done_restart: valid/busy=%b want 01", {valid, busy}); end
        wait_end(40, cycles);
        n_checks++; if (cycles !== 9 || valid !== 1'b1) begin n_fail++; $display("[TB] FAIL refetch: cycles=%0d valid=%b want 9 1", cycles, valid); end
        n_checks++; if (freq !== 32'h11 || dram_size !== 32'h55) begin n_fail++; $display("[TB] FAIL refetch_vals: got %h %h want 11 55", freq, dram_size); end
        n_checks++; if (exp_adr_q.size() !== 0) begin n_fail++; $display("[TB] FAIL refetch_adr_count: %0d expected requests missing", exp_adr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_fetch();
        test_err_abort();
        test_retry();
        test_timeout();
        test_ack_err();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
